// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
//   Shared definitions for the UART0 transmitter: state encoding, the
//   oversample constants and the shift-register idle value.
package uart_tx_pkg;

  // Oversample ticks per bit. This is shared with the receiver and is not tunable.
  localparam int         OVS       = 16;
  localparam logic [3:0] OVS_LAST  = 4'(OVS - 1);

  // Shift-register value at reset and when idle. An all-ones value keeps the line high.
  localparam logic [7:0] SHIFT_RST = 8'hff;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // acc is the XOR of the data bits. Even parity sends acc as-is so that
  // the total count of ones is even. Odd parity sends ~acc.
  function automatic logic parity_bit(input logic even, input logic acc);
    return even ? acc : ~acc;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if
//   Groups the register-file side and the serial side of the transmitter.
//   master: register file / baud generator (drives strobes and config,
//           observes status). slave: uart_tx.
//   Signals: tx_data_sample (x16 tick), tx_en, no_parity, ev_parity,
//            wr_data_flag, tx_data_in[7:0] -> transmitter;
//            txd, tx_ready, tx_busy, tx_done, state_dbg <- transmitter.
//   Handshake: a byte is transferred on a rising clk edge where
//   wr_data_flag & tx_ready are both 1. wr_data_flag while tx_ready=0 is
//   dropped, and nothing is held or retried.
interface uart_tx_if;
  logic                  tx_data_sample;
  logic                  tx_en;
  logic                  no_parity;
  logic                  ev_parity;
  logic                  wr_data_flag;
  logic [7:0]            tx_data_in;
  logic                  txd;
  logic                  tx_ready;
  logic                  tx_busy;
  logic                  tx_done;
  uart_tx_pkg::tx_state_e state_dbg;

  modport master (
    output tx_data_sample, tx_en, no_parity, ev_parity, wr_data_flag, tx_data_in,
    input  txd, tx_ready, tx_busy, tx_done, state_dbg
  );

  modport slave (
    input  tx_data_sample, tx_en, no_parity, ev_parity, wr_data_flag, tx_data_in,
    output txd, tx_ready, tx_busy, tx_done, state_dbg
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx
//   UART0 serial transmitter. It sends a start bit, 8 data bits LSB first,
//   an optional parity bit and STOP_BITS stop bits. The bit period is 16
//   x16 ticks. A one-byte holding register sits in front of the shift
//   register, so the next byte can be queued during a frame.
//   Ports: clk, rst (synchronous, active high), bus (uart_tx_if.slave).
//   Parameter: STOP_BITS (1 or 2).
module uart_tx import uart_tx_pkg::*; #(
  parameter int STOP_BITS = 1
) (
  input  logic    clk,
  input  logic    rst,
  uart_tx_if.slave bus
);

  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_e  state_q,      state_d;
  logic       txd_q,        txd_d;
  logic [7:0] hold_q,       hold_d;
  logic       hold_valid_q, hold_valid_d;
  logic [7:0] shift_q,      shift_d;
  logic [3:0] sample_cnt_q, sample_cnt_d;
  logic [2:0] bit_cnt_q,    bit_cnt_d;
  logic       stop_cnt_q,   stop_cnt_d;
  logic       acc_q,        acc_d;
  logic       no_par_q,     no_par_d;
  logic       ev_par_q,     ev_par_d;
  logic       done_q,       done_d;

  logic tx_pos;
  logic bit_end;
  logic wr_accept;
  logic load_frame;

  assign tx_pos    = bus.tx_en & bus.tx_data_sample;
  assign bit_end   = tx_pos & (sample_cnt_q == OVS_LAST);
  assign wr_accept = bus.wr_data_flag & bus.tx_ready;

  assign bus.tx_ready  = bus.tx_en & ~hold_valid_q;
  assign bus.txd       = txd_q;
  assign bus.tx_busy   = (state_q != ST_IDLE);
  assign bus.tx_done   = done_q;
  assign bus.state_dbg = state_q;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    acc_d        = acc_q;
    no_par_d     = no_par_q;
    ev_par_d     = ev_par_q;
    done_d       = 1'b0;
    load_frame   = 1'b0;
    txd_d        = 1'b1;

    // The sample counter free-runs within a frame and wraps at the end of each bit.
    if (tx_pos && (state_q != ST_IDLE)) sample_cnt_d = sample_cnt_q + 4'd1;

    case (state_q)
      ST_IDLE: begin
        if (tx_pos && hold_valid_q) load_frame = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d   = {1'b1, shift_q[7:1]};
          acc_d     = acc_q ^ shift_q[0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d    = no_par_q ? ST_STOP : ST_PARITY;
            stop_cnt_d = 1'b0;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == STOP_LAST) begin
            done_d = 1'b1;
            // If a byte is already queued, the next start bit follows with no idle tick.
            if (hold_valid_q) load_frame = 1'b1;
            else              state_d    = ST_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The parity mode is frozen here, so a config change mid-frame applies to the next frame.
    if (load_frame) begin
      state_d      = ST_START;
      shift_d      = hold_q;
      hold_valid_d = 1'b0;
      no_par_d     = bus.no_parity;
      ev_par_d     = bus.ev_parity;
      acc_d        = 1'b0;
      sample_cnt_d = 4'd0;
      bit_cnt_d    = 3'd0;
      stop_cnt_d   = 1'b0;
    end

    // A write cannot coincide with load_frame, because tx_ready is low whenever hold_valid is set.
    if (wr_accept) begin
      hold_d       = bus.tx_data_in;
      hold_valid_d = 1'b1;
    end

    // Clearing tx_en aborts the frame at once and drops any queued byte.
    if (!bus.tx_en) begin
      state_d      = ST_IDLE;
      hold_valid_d = 1'b0;
      shift_d      = SHIFT_RST;
      sample_cnt_d = 4'd0;
      bit_cnt_d    = 3'd0;
      stop_cnt_d   = 1'b0;
      acc_d        = 1'b0;
      done_d       = 1'b0;
    end

    // txd is registered from the next state, so the line changes on the same edge as the state.
    case (state_d)
      ST_IDLE:   txd_d = 1'b1;
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
      ST_PARITY: txd_d = parity_bit(ev_par_d, acc_d);
      ST_STOP:   txd_d = 1'b1;
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      txd_q        <= 1'b1;
      hold_q       <= 8'h00;
      hold_valid_q <= 1'b0;
      shift_q      <= SHIFT_RST;
      sample_cnt_q <= 4'd0;
      bit_cnt_q    <= 3'd0;
      stop_cnt_q   <= 1'b0;
      acc_q        <= 1'b0;
      no_par_q     <= 1'b0;
      ev_par_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      txd_q        <= txd_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      acc_q        <= acc_d;
      no_par_q     <= no_par_d;
      ev_par_q     <= ev_par_d;
      done_q       <= done_d;
    end
  end

endmodule
